// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: loader states,
// word framing constants and a byte-index helper.
package imem_uart_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_e;

  function automatic logic is_last_byte(input logic [BYTE_IDX_W-1:0] idx);
    return idx == BYTE_IDX_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/imem_uart_loader_byte_assembler.sv
// Collects little-endian bytes into a 32-bit word. The word output already
// includes the byte being shifted in, so the 4th byte completes it that cycle.
module imem_uart_loader_byte_assembler
  import imem_uart_loader_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  input  logic [BYTE_IDX_W-1:0] idx_i,
  output logic [31:0]           word_o,
  output logic                  full_o
);

  logic [31:0] word_q;
  logic [31:0] word_d;

  always_comb begin
    word_d = word_q;
    if (shift_i) begin
      unique case (idx_i)
        2'd0:    word_d[7:0]   = byte_i;
        2'd1:    word_d[15:8]  = byte_i;
        2'd2:    word_d[23:16] = byte_i;
        default: word_d[31:24] = byte_i;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_d;
  assign full_o = shift_i && is_last_byte(idx_i);

endmodule

// File: rtl/imem_uart_loader.sv
// Loads instruction RAM from a UART byte stream: a little-endian word-count
// header followed by that many little-endian words, with timeout and checksum.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  loading_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic [31:0]           csum_o
);

  localparam logic [32:0] MAX_WORDS    = 33'(1) << ADDR_WIDTH;
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  loader_state_e         state_q, state_d;
  logic [BYTE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]           timeout_q, timeout_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [ADDR_WIDTH:0]   n_words_q, n_words_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           csum_q, csum_d;

  logic                  rx_ready;
  logic                  accept;
  logic                  timeout_hit;
  logic [31:0]           asm_word;
  logic                  asm_full;

  assign rx_ready    = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign accept      = rx_valid_i && rx_ready;
  assign timeout_hit = TIMEOUT_EN && !accept && (timeout_q == TIMEOUT_LAST);

  imem_uart_loader_byte_assembler u_assembler (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .shift_i  (accept),
    .byte_i   (rx_data_i),
    .idx_i    (byte_cnt_q),
    .word_o   (asm_word),
    .full_o   (asm_full)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    timeout_d    = timeout_q;
    word_count_d = word_count_q;
    n_words_d    = n_words_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    csum_d       = csum_q;

    if (abort_i) begin
      // Abort keeps the session statistics so software can see how far it got.
      state_d    = ST_IDLE;
      byte_cnt_d = '0;
      timeout_d  = '0;
    end else begin
      if (accept) begin
        byte_cnt_d = byte_cnt_q + BYTE_IDX_W'(1);
        timeout_d  = '0;
      end else if (rx_ready) begin
        timeout_d = timeout_q + 32'd1;
      end

      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_d      = ST_HDR;
            byte_cnt_d   = '0;
            timeout_d    = '0;
            word_count_d = '0;
            csum_d       = '0;
            addr_d       = '0;
          end
        end
        ST_HDR: begin
          if (asm_full) begin
            if (asm_word == 32'd0) begin
              state_d = ST_DONE;
            end else if ({1'b0, asm_word} > MAX_WORDS) begin
              state_d = ST_ERR;
            end else begin
              state_d   = ST_DATA;
              n_words_d = asm_word[ADDR_WIDTH:0];
            end
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
        ST_DATA: begin
          if (asm_full) begin
            state_d = ST_WRITE;
            wdata_d = asm_word;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
        ST_WRITE: begin
          csum_d       = csum_q ^ wdata_q;
          word_count_d = word_count_q + (ADDR_WIDTH + 1)'(1);
          addr_d       = addr_q + ADDR_WIDTH'(1);
          state_d      = (word_count_d == n_words_q) ? ST_DONE : ST_DATA;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      timeout_q    <= '0;
      word_count_q <= '0;
      n_words_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      timeout_q    <= timeout_d;
      word_count_q <= word_count_d;
      n_words_q    <= n_words_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      csum_q       <= csum_d;
    end
  end

  // An abort landing on the write cycle suppresses that write.
  assign imem_we_o    = (state_q == ST_WRITE) && !abort_i;
  assign rx_ready_o   = rx_ready;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign loading_o    = rx_ready || (state_q == ST_WRITE);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = (state_q == ST_ERR);
  assign word_count_o = word_count_q;
  assign csum_o       = csum_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: table of frame headers with random payloads
// against a frame-level model, plus directed latency, timeout, abort and reset cases.
module tb_imem_uart_loader;

  localparam int AW = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rxValid = 1'b0;
  logic [7:0]    rxData = 8'h00;
  logic          rxReady;
  logic          imemWe;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemWdata;
  logic          loading;
  logic          done;
  logic          error;
  logic [AW:0]   wordCount;
  logic [31:0]   csum;

  imem_uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock_i      (clock),
    .resetn_i     (resetn),
    .start_i      (start),
    .abort_i      (abort),
    .rx_data_i    (rxData),
    .rx_valid_i   (rxValid),
    .rx_ready_o   (rxReady),
    .imem_we_o    (imemWe),
    .imem_addr_o  (imemAddr),
    .imem_wdata_o (imemWdata),
    .loading_o    (loading),
    .done_o       (done),
    .error_o      (error),
    .word_count_o (wordCount),
    .csum_o       (csum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hdr;
    bit          expDone;
    bit          expError;
    int          expCount;
    int          maxGap;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  txBytes[$];
  logic [31:0] expWords[$];
  int          wrAddr[$];
  logic [31:0] wrData[$];
  int          readyInWrite = 0;

  // Record every write strobe seen between clock edges.
  always @(negedge clock) begin
    if (imemWe === 1'b1) begin
      wrAddr.push_back(int'(imemAddr));
      wrData.push_back(imemWdata);
      if (rxReady) readyInWrite++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void appendWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) txBytes.push_back(w[8*b +: 8]);
  endfunction

  task automatic sendByte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clock);
    rxValid = 1'b1;
    rxData  = b;
    while (!rxReady && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) checkOutput("rxReadyWait", 32'(rxReady), 32'd1);
    @(negedge clock);
    rxValid = 1'b0;
  endtask

  task automatic applyStimulus(input int maxGap);
    while (txBytes.size() > 0) begin
      sendByte(txBytes.pop_front(), (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wrAddr.delete();
    wrData.delete();
    readyInWrite = 0;
  endtask

  task automatic waitEnd();
    int n = 0;
    while (!(done || error) && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  function automatic logic [31:0] xorAll();
    logic [31:0] x = '0;
    foreach (expWords[i]) x ^= expWords[i];
    return x;
  endfunction

  task automatic checkWrites(input string tag);
    checkOutput({tag, ".writes"}, 32'(wrData.size()), 32'(expWords.size()));
    for (int i = 0; i < expWords.size(); i++) begin
      if (i < wrData.size()) begin
        checkOutput({tag, ".addr"}, 32'(wrAddr[i]), 32'(i));
        checkOutput({tag, ".data"}, wrData[i], expWords[i]);
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'd0,          1'b1, 1'b0, 0,  2};
    vecs[1] = '{32'd1,          1'b1, 1'b0, 1,  3};
    vecs[2] = '{32'd5,          1'b1, 1'b0, 5,  2};
    vecs[3] = '{32'd16,         1'b1, 1'b0, 16, 1};
    vecs[4] = '{32'd17,         1'b0, 1'b1, 0,  2};
    vecs[5] = '{32'h0000_0100,  1'b0, 1'b1, 0,  0};
    vecs[6] = '{32'hFFFF_FFFF,  1'b0, 1'b1, 0,  1};
    vecs[7] = '{32'd3,          1'b1, 1'b0, 3,  0};

    // Reset state
    @(negedge clock);
    checkOutput("rst.loading", 32'(loading), 32'd0);
    checkOutput("rst.rxReady", 32'(rxReady), 32'd0);
    checkOutput("rst.we", 32'(imemWe), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.error", 32'(error), 32'd0);
    checkOutput("rst.count", 32'(wordCount), 32'd0);
    checkOutput("rst.csum", csum, 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Two-word frame with exact write latency
    doStart();
    checkOutput("t1.loading", 32'(loading), 32'd1);
    txBytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    applyStimulus(0);
    checkOutput("t1.we0", 32'(imemWe), 32'd1);
    checkOutput("t1.addr0", 32'(imemAddr), 32'd0);
    checkOutput("t1.data0", imemWdata, 32'h1234_5678);
    txBytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(0);
    checkOutput("t1.we1", 32'(imemWe), 32'd1);
    checkOutput("t1.addr1", 32'(imemAddr), 32'd1);
    checkOutput("t1.data1", imemWdata, 32'hDEAD_BEEF);
    @(negedge clock);
    checkOutput("t1.done", 32'(done), 32'd1);
    checkOutput("t1.count", 32'(wordCount), 32'd2);
    checkOutput("t1.csum", csum, 32'hCC99_E897);
    checkOutput("t1.writes", 32'(wrData.size()), 32'd2);

    // Empty frame completes on the cycle after its header
    doStart();
    txBytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(0);
    checkOutput("t2.done", 32'(done), 32'd1);
    checkOutput("t2.count", 32'(wordCount), 32'd0);
    checkOutput("t2.writes", 32'(wrData.size()), 32'd0);

    // Table of headers with random payloads
    foreach (vecs[v]) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      expWords.delete();
      doStart();
      appendWord(vecs[v].hdr);
      if (vecs[v].hdr != 0 && vecs[v].hdr <= (32'd1 << AW)) begin
        for (int w = 0; w < int'(vecs[v].hdr); w++) begin
          expWords.push_back($urandom);
          appendWord(expWords[w]);
        end
      end
      applyStimulus(vecs[v].maxGap);
      waitEnd();
      @(negedge clock);
      checkOutput({tag, ".done"}, 32'(done), 32'(vecs[v].expDone));
      checkOutput({tag, ".error"}, 32'(error), 32'(vecs[v].expError));
      checkOutput({tag, ".count"}, 32'(wordCount), 32'(vecs[v].expCount));
      checkOutput({tag, ".csum"}, csum, xorAll());
      checkOutput({tag, ".loading"}, 32'(loading), 32'd0);
      checkWrites(tag);
    end

    // Stall mid-word: error exactly after the idle budget, partial word dropped
    doStart();
    txBytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    applyStimulus(0);
    repeat (TO - 1) @(negedge clock);
    checkOutput("t4.errEarly", 32'(error), 32'd0);
    @(negedge clock);
    checkOutput("t4.error", 32'(error), 32'd1);
    checkOutput("t4.writes", 32'(wrData.size()), 32'd0);

    // Back-to-back bytes across write cycles
    expWords.delete();
    doStart();
    appendWord(32'd3);
    for (int w = 0; w < 3; w++) begin
      expWords.push_back($urandom);
      appendWord(expWords[w]);
    end
    applyStimulus(0);
    waitEnd();
    checkOutput("t5.done", 32'(done), 32'd1);
    checkOutput("t5.readyInWrite", 32'(readyInWrite), 32'd0);
    checkOutput("t5.csum", csum, xorAll());
    checkWrites("t5");

    // Abort mid-data keeps statistics, then abort beats start, then clean reload
    expWords.delete();
    doStart();
    expWords.push_back($urandom);
    appendWord(32'd2);
    appendWord(expWords[0]);
    txBytes.push_back(8'h11);
    txBytes.push_back(8'h22);
    applyStimulus(1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checkOutput("t6.loading", 32'(loading), 32'd0);
    checkOutput("t6.done", 32'(done), 32'd0);
    checkOutput("t6.error", 32'(error), 32'd0);
    checkOutput("t6.count", 32'(wordCount), 32'd1);
    checkOutput("t6.csum", csum, expWords[0]);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("t6.abortWins", 32'(loading), 32'd0);
    expWords.delete();
    doStart();
    expWords.push_back($urandom);
    appendWord(32'd1);
    appendWord(expWords[0]);
    applyStimulus(2);
    waitEnd();
    checkOutput("t6.reloadDone", 32'(done), 32'd1);
    checkOutput("t6.reloadCsum", csum, expWords[0]);
    checkWrites("t6.reload");

    // Asynchronous reset in the middle of a load
    doStart();
    appendWord(32'd2);
    appendWord($urandom | 32'h1);
    txBytes.push_back(8'h33);
    applyStimulus(0);
    #2 resetn = 1'b0;
    #1;
    checkOutput("t7.loading", 32'(loading), 32'd0);
    checkOutput("t7.rxReady", 32'(rxReady), 32'd0);
    checkOutput("t7.count", 32'(wordCount), 32'd0);
    checkOutput("t7.csum", csum, 32'd0);
    checkOutput("t7.addr", 32'(imemAddr), 32'd0);
    checkOutput("t7.wdata", imemWdata, 32'd0);
    checkOutput("t7.doneErr", {30'd0, done, error}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
